// File: rtl/tick_gen.sv
// tick_gen: NUM_CH independent programmable square-wave generators.
// Each channel toggles clk_out every H clk cycles and pulses tick for one cycle after each toggle.
// Optional feature: define TICK_GEN_GRACEFUL_STOP_EN so that dropping enable lets a running high
// phase finish before the channel goes idle. Without the macro, dropping enable stops the channel
// at the next edge and forces clk_out low.
module tick_gen #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH*CNT_W-1:0]   half_period,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         active
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state;
        logic [CNT_W-1:0]   cnt;
        logic [CNT_W-1:0]   shadow;
        logic               co_q;
        logic               tk_q;
        logic               act_q;
        logic [CNT_W-1:0]   h;
        logic               terminal;

        assign h        = half_period[i*CNT_W +: CNT_W];
        // Shadow is never zero outside IDLE, so shadow-1 cannot underflow while counting.
        assign terminal = (cnt == shadow - CNT_W'(1));

        assign clk_out[i] = co_q;
        assign tick[i]    = tk_q;
        assign active[i]  = act_q;

        // Per-channel state machine: counter, shadow half-period and registered outputs.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                shadow <= '0;
                co_q   <= 1'b0;
                tk_q   <= 1'b0;
                act_q  <= 1'b0;
            end else begin
                tk_q <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        cnt  <= '0;
                        co_q <= 1'b0;
                        if (enable[i] && (h != '0)) begin
                            state  <= ST_RUN;
                            shadow <= h;
                            act_q  <= 1'b1;
                        end
                    end
                    ST_RUN, ST_STOP: begin
`ifdef TICK_GEN_GRACEFUL_STOP_EN
                        if (!enable[i] && (state == ST_RUN) && !co_q) begin
                            // Low phase: nothing to finish, stop right away.
                            state <= ST_IDLE;
                            cnt   <= '0;
                            act_q <= 1'b0;
                        end else if (!terminal) begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= enable[i] ? ST_RUN : ST_STOP;
                        end else if (!enable[i]) begin
                            // End of the high phase being drained: fall, pulse, stop.
                            state <= ST_IDLE;
                            cnt   <= '0;
                            co_q  <= 1'b0;
                            tk_q  <= 1'b1;
                            act_q <= 1'b0;
                        end else if (h == '0) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            co_q  <= 1'b0;
                            tk_q  <= co_q;
                            act_q <= 1'b0;
                        end else begin
                            state  <= ST_RUN;
                            cnt    <= '0;
                            co_q   <= ~co_q;
                            tk_q   <= 1'b1;
                            shadow <= h;
                        end
`else
                        if (!enable[i]) begin
                            // Abrupt stop: may truncate a high phase, no tick.
                            state <= ST_IDLE;
                            cnt   <= '0;
                            co_q  <= 1'b0;
                            act_q <= 1'b0;
                        end else if (!terminal) begin
                            cnt <= cnt + CNT_W'(1);
                        end else if (h == '0) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            co_q  <= 1'b0;
                            tk_q  <= co_q;
                            act_q <= 1'b0;
                        end else begin
                            cnt    <= '0;
                            co_q   <= ~co_q;
                            tk_q   <= 1'b1;
                            shadow <= h;
                        end
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        co_q  <= 1'b0;
                        act_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
